// File: rtl/wb_mem_bridge.sv
// wb_mem_bridge: Wishbone slave borrowing the uP16 RAM port via a CPU hold handshake.
module wb_mem_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SRAM_LAT  = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cpu_hold_o,
  input  logic        cpu_hold_ack_i,
  output logic        br_active_o,
  output logic        br_en_o,
  output logic        br_rw_o,
  output logic [11:0] br_addr_o,
  output logic [15:0] br_data_o,
  input  logic [15:0] br_data_i
);
  typedef enum logic [2:0] {IDLE, HOLD, READ, WRITE, ACK} state_t;
  state_t      state, state_n;
  logic [11:0] addr;
  logic        we;
  logic [1:0]  sel;
  logic [15:0] dat, dat_n, cap, cap_n;
  logic [1:0]  cnt;
  logic        hit, last, mem_n;
  logic        unused;
  assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[11], wbs_adr_i[1:0]};
  assign hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:14] == BASE_ADDR[31:14]);
  assign last = cnt == 2'(SRAM_LAT);
  assign mem_n = state_n == READ || state_n == WRITE;
  always_comb begin
    state_n = state;
    dat_n   = dat;
    cap_n   = cap;
    case (state)
      IDLE: if (hit) begin
        state_n = wbs_sel_i[1:0] == 2'b00 ? ACK : HOLD;
        dat_n   = wbs_dat_i[15:0];
        cap_n   = '0;
      end
      HOLD: state_n = !wbs_cyc_i ? IDLE : !cpu_hold_ack_i ? HOLD : (we && sel == 2'b11) ? WRITE : READ;
      READ: if (!wbs_cyc_i) state_n = IDLE;
        else if (last) begin
          state_n = we ? WRITE : ACK;
          cap_n   = br_data_i;
          dat_n   = {sel[1] ? dat[15:8] : br_data_i[15:8], sel[0] ? dat[7:0] : br_data_i[7:0]};
        end
      WRITE: state_n = wbs_cyc_i ? ACK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      we          <= 1'b0;
      sel         <= '0;
      dat         <= '0;
      cap         <= '0;
      cnt         <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      cpu_hold_o  <= 1'b0;
      br_active_o <= 1'b0;
      br_en_o     <= 1'b0;
      br_rw_o     <= 1'b0;
      br_addr_o   <= '0;
      br_data_o   <= '0;
    end else begin
      state <= state_n;
      dat   <= dat_n;
      cap   <= cap_n;
      cnt   <= state == READ ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && hit) begin
        addr <= {wbs_adr_i[13:12], 1'b0, wbs_adr_i[10:2]};
        we   <= wbs_we_i;
        sel  <= wbs_sel_i[1:0];
      end
      wbs_ack_o   <= state_n == ACK;
      wbs_dat_o   <= (state_n == ACK && !we) ? {16'h0, cap_n} : '0;
      cpu_hold_o  <= state_n != IDLE;
      br_active_o <= mem_n;
      br_en_o     <= mem_n;
      br_rw_o     <= state_n == WRITE;
      br_addr_o   <= mem_n ? addr : '0;
      br_data_o   <= state_n == WRITE ? dat_n : '0;
    end
  end
endmodule

// File: tb/tb_wb_mem_bridge.sv
// tb_wb_mem_bridge: directed transactions checked cycle by cycle against a timing-rule model.
module tb_wb_mem_bridge;
  localparam int L = 1;
  localparam logic [31:0] BASE = 32'h3000_0000;
  typedef struct packed {
    logic hold, active, en, rw;
    logic [11:0] addr;
    logic [15:0] wd;
    logic ack;
    logic [31:0] dat;
  } vec_t;
  logic clk = 0, rst = 0;
  logic stb = 0, cyc = 0, we = 0, hold_ack = 1;
  logic [3:0] sel = 0;
  logic [31:0] wdat = 0, adr = 0;
  logic ack, hold, active, en, rw;
  logic [31:0] rdat;
  logic [11:0] baddr;
  logic [15:0] bdo, bdi;
  int nvec = 0, nerr = 0;
  vec_t exq[$];
  logic [15:0] ram [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] rp [L];
  always #5 clk = ~clk;
  wb_mem_bridge #(.BASE_ADDR(BASE), .SRAM_LAT(L)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cpu_hold_o(hold), .cpu_hold_ack_i(hold_ack), .br_active_o(active), .br_en_o(en),
    .br_rw_o(rw), .br_addr_o(baddr), .br_data_o(bdo), .br_data_i(bdi));
  // RAM bank behind the mux: registered read with L cycles latency
  always @(posedge clk) begin
    rp[0] <= ram[baddr];
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    if (en && rw) ram[baddr] <= bdo;
  end
  assign bdi = rp[L-1];
  function automatic vec_t dut_vec();
    return '{hold, active, en, rw, baddr, bdo, ack, rdat};
  endfunction
  function automatic vec_t mk(logic h, logic a, logic r, logic [11:0] ad, logic [15:0] d, logic k, logic [31:0] o);
    return '{h, a, a, r, ad, d, k, o};
  endfunction
  always @(negedge clk) begin
    vec_t e, g;
    e = exq.size() != 0 ? exq.pop_front() : '0;
    g = dut_vec();
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL cycle t=%0t got hold=%b act=%b en=%b rw=%b addr=%h wd=%h ack=%b dat=%h exp hold=%b act=%b en=%b rw=%b addr=%h wd=%h ack=%b dat=%h",
        $time, g.hold, g.active, g.en, g.rw, g.addr, g.wd, g.ack, g.dat,
        e.hold, e.active, e.en, e.rw, e.addr, e.wd, e.ack, e.dat);
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                     input int dly, input int abort_k, input int rst_k, input int exp_n);
    vec_t sch[$];
    logic [11:0] ba;
    logic [15:0] old, m;
    int widx, last;
    logic hit;
    hit = a[31:14] == BASE[31:14];
    ba = {a[13:12], 1'b0, a[10:2]};
    widx = -1;
    m = d[15:0];
    @(posedge clk); #1;
    if (hit && s[1:0] == 2'b00) sch.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    else if (hit) begin
      repeat (1 + dly) sch.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      old = ref_mem[ba];
      if (!(w && s[1:0] == 2'b11)) begin
        repeat (L + 1) sch.push_back(mk(1, 1, 0, ba, 0, 0, 0));
        m = {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
      end
      if (w) begin
        widx = sch.size();
        sch.push_back(mk(1, 1, 1, ba, m, 0, 0));
      end
      sch.push_back(mk(1, 0, 0, 0, 0, 1, w ? 32'h0 : {16'h0, old}));
    end
    if (exp_n >= 0) check("ack_latency", sch.size(), exp_n);
    last = abort_k >= 0 ? abort_k : !hit ? 2 : sch.size() - 1;
    while (sch.size() > last + 1) void'(sch.pop_back());
    if (widx >= 0 && widx <= last && rst_k < 0) ref_mem[ba] = m;
    exq.push_back('0);
    foreach (sch[i]) exq.push_back(sch[i]);
    adr = a; we = w; sel = s; wdat = d; stb = 1; cyc = 1; hold_ack = dly == 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == dly) hold_ack = 1;
      if (k == rst_k) begin
        #2 rst = 1;
        exq.delete();
        #1 check("async_reset_outputs", 32'(dut_vec() != '0), 0);
        stb = 0; cyc = 0; hold_ack = 1;
        #3 rst = 0;
        return;
      end
      if (k == last) begin stb = 0; cyc = 0; hold_ack = 1; end
    end
  endtask
  initial begin
    foreach (ram[i]) begin ram[i] = 0; ref_mem[i] = 0; end
    #1 rst = 1;
    #1 check("reset_outputs", 32'(dut_vec() != '0), 0);
    #20 rst = 0;
    txn(32'h3000_0C08, 1, 4'hF, 32'h0000_BEEF, 0, -1, -1, 3);
    @(posedge clk); #1 check("ram_full_write", ram[12'h102], 16'hBEEF);
    txn(32'h3000_0C08, 0, 4'hF, 0, 0, -1, -1, 4);
    txn(32'h3000_0C08, 1, 4'h1, 32'h0000_0012, 0, -1, -1, 5);
    @(posedge clk); #1 check("ram_partial_lo", ram[12'h102], 16'hBE12);
    txn(32'h3000_0C08, 1, 4'h2, 32'h0000_3400, 0, -1, -1, 5);
    @(posedge clk); #1 check("ram_partial_hi", ram[12'h102], 16'h3412);
    txn(32'h3000_3008, 1, 4'hF, 32'h0000_A5C3, 5, -1, -1, 8);
    @(posedge clk); #1 check("ram_bank3", ram[12'hC02], 16'hA5C3);
    txn(32'h3000_0408, 0, 4'h3, 0, 2, -1, -1, 6);
    txn(32'h3000_0000, 1, 4'h0, 32'h0000_FFFF, 0, -1, -1, 1);
    txn(32'h3000_3008, 1, 4'h1, 32'h0000_00FF, 0, 1, -1, -1);
    txn(32'h3000_3008, 1, 4'hF, 32'h0000_1111, 3, 1, -1, -1);
    txn(32'h3001_0000, 1, 4'hF, 32'h0000_2222, 0, -1, -1, -1);
    @(posedge clk); #1 check("ram_after_aborts", ram[12'hC02], 16'hA5C3);
    txn(32'h3000_3008, 0, 4'h3, 0, 0, -1, 1, -1);
    txn(32'h3000_3008, 0, 4'h3, 0, 0, -1, -1, 4);
    txn(32'h3000_1004, 1, 4'hF, 32'h0000_5A5A, 0, 1, -1, -1);
    @(posedge clk); #1 check("ram_write_no_ack", ram[12'h401], 16'h5A5A);
    check("ram_zero_page", ram[12'h000], 16'h0000);
    begin
      int bad = 0;
      foreach (ram[i]) if (ram[i] !== ref_mem[i]) bad++;
      check("ram_image", bad, 0);
    end
    repeat (3) @(posedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
